// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target buffer / direction predictor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bp_pkg;

    // 2-bit direction counter encodings; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    // Value written into a freshly allocated entry: weakly taken.
    localparam logic [1:0] CNT_ALLOC = 2'(WT);

    // Width of the table index for a given entry count.
    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // Width of the stored tag: PC minus index bits minus the word-offset bits.
    function automatic int tag_w(input int addr_w, input int entries);
        return addr_w - $clog2(entries) - 2;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Up/down saturating counter with parallel load and a configurable reset value.
// Latency: new value visible one cycle after inc/dec/load is asserted.
// Backpressure: none; inc and dec together cancel, load has priority.
module bp_sat_counter #(
    parameter int           W       = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Counter register: load wins, otherwise step toward the requested rail and stick there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc && !i_dec && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, resolve-time mispredict detection and stats.
// Latency: lookup and resolve are combinational; table writes are visible the cycle after the edge.
// Backpressure: none; one update per cycle, qualified by upd_valid; flush drops a same-cycle update.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int          ENTRIES   = 16,
    parameter int          ADDR_W    = 32,
    parameter logic [1:0]  CNT_INIT  = 2'b01,
    // Starting value of both statistics counters after reset (normally zero).
    parameter logic [31:0] STAT_INIT = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic              upd_is_branch,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] recovery_pc,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispred
);

    localparam int IDX_W = idx_w(ENTRIES);
    localparam int TAG_W = tag_w(ADDR_W, ENTRIES);

    // Table storage in flops so flush and reset can clear every valid bit in one cycle.
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [1:0]         w_cnt    [ENTRIES];

    // ------------------------------------------------------------------
    // Lookup (IF)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic [1:0]       w_if_cnt;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[ADDR_W-1:IDX_W+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_if_cnt = w_cnt[w_if_idx];

    // Counter at or above WT means the MSB is set: predict taken.
    assign pred_taken  = w_if_hit && (w_if_cnt >= CNT_ALLOC);
    assign pred_target = pred_taken ? r_target[w_if_idx] : (if_pc + ADDR_W'(4));

    // ------------------------------------------------------------------
    // Resolve (EX)
    // ------------------------------------------------------------------
    logic w_actual;

    assign w_actual    = upd_is_branch && upd_taken;
    assign mispredict  = upd_valid &&
                         (w_actual ? !(upd_pred_taken && (upd_pred_target == upd_target))
                                   : upd_pred_taken);
    assign recovery_pc = w_actual ? upd_target : (upd_pc + ADDR_W'(4));

    // ------------------------------------------------------------------
    // Update decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic             w_upd_en;
    logic             w_br_hit;
    logic             w_br_alloc;
    logic             w_alias_inv;

    assign w_upd_idx   = upd_pc[IDX_W+1:2];
    assign w_upd_tag   = upd_pc[ADDR_W-1:IDX_W+2];
    assign w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    // A same-cycle flush suppresses every table write from the update.
    assign w_upd_en    = upd_valid && !flush;
    assign w_br_hit    = w_upd_en && upd_is_branch && w_upd_hit;
    assign w_br_alloc  = w_upd_en && upd_is_branch && !w_upd_hit && upd_taken;
    // A non-branch that matches an entry means the entry aliased onto it; drop it.
    assign w_alias_inv = w_upd_en && !upd_is_branch && w_upd_hit;

    // Valid bits: flush clears all, otherwise allocate sets and aliasing clears one entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_br_alloc) begin
            r_valid[w_upd_idx] <= 1'b1;
        end else if (w_alias_inv) begin
            r_valid[w_upd_idx] <= 1'b0;
        end
    end

    // Tag and target: written on allocate; target also refreshed on every taken hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (w_br_alloc) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= upd_target;
        end else if (w_br_hit && upd_taken) begin
            r_target[w_upd_idx] <= upd_target;
        end
    end

    // Per-entry direction counters; flush leaves them untouched.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        logic w_sel;

        assign w_sel = (w_upd_idx == IDX_W'(g));

        bp_sat_counter #(
            .W       (2),
            .RST_VAL (CNT_INIT)
        ) u_dir_cnt (
            .clk        (clk),
            .rst_n      (reset),
            .i_inc      (w_sel && w_br_hit && upd_taken),
            .i_dec      (w_sel && w_br_hit && !upd_taken),
            .i_load     (w_sel && w_br_alloc),
            .i_load_val (CNT_ALLOC),
            .o_cnt      (w_cnt[g])
        );
    end

    // ------------------------------------------------------------------
    // Statistics: count regardless of flush, saturate at all-ones.
    // ------------------------------------------------------------------
    bp_sat_counter #(
        .W       (32),
        .RST_VAL (STAT_INIT)
    ) u_stat_branches (
        .clk        (clk),
        .rst_n      (reset),
        .i_inc      (upd_valid && upd_is_branch),
        .i_dec      (1'b0),
        .i_load     (1'b0),
        .i_load_val (32'h0),
        .o_cnt      (stat_branches)
    );

    bp_sat_counter #(
        .W       (32),
        .RST_VAL (STAT_INIT)
    ) u_stat_mispred (
        .clk        (clk),
        .rst_n      (reset),
        .i_inc      (mispredict),
        .i_dec      (1'b0),
        .i_load     (1'b0),
        .i_load_val (32'h0),
        .o_cnt      (stat_mispred)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations are queued as each step is driven
// and drained against the outputs shortly after, away from the rising edge.
// A second instance starts its stats near the rail to exercise saturation.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic        upd_is_branch;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        pred_taken;
    logic [31:0] pred_target;
    logic        mispredict;
    logic [31:0] recovery_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    logic        s_pred_taken;
    logic [31:0] s_pred_target;
    logic        s_mispredict;
    logic [31:0] s_recovery_pc;
    logic [31:0] s_stat_branches;
    logic [31:0] s_stat_mispred;

    int n_vec = 0;
    int n_err = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    branch_predictor dut (
        .clk             (clk),
        .reset           (rst_n),
        .flush           (flush),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_is_branch   (upd_is_branch),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .recovery_pc     (recovery_pc),
        .stat_branches   (stat_branches),
        .stat_mispred    (stat_mispred)
    );

    branch_predictor #(.STAT_INIT(32'hFFFF_FFFE)) dut_sat (
        .clk             (clk),
        .reset           (rst_n),
        .flush           (flush),
        .if_pc           (if_pc),
        .pred_taken      (s_pred_taken),
        .pred_target     (s_pred_target),
        .upd_valid       (upd_valid),
        .upd_is_branch   (upd_is_branch),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (s_mispredict),
        .recovery_pc     (s_recovery_pc),
        .stat_branches   (s_stat_branches),
        .stat_mispred    (s_stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input string tag);
        if (tag == "pred_tk")  return {31'b0, pred_taken};
        if (tag == "pred_tgt") return pred_target;
        if (tag == "mispred")  return {31'b0, mispredict};
        if (tag == "recov")    return recovery_pc;
        if (tag == "stat_br")  return stat_branches;
        if (tag == "stat_mp")  return stat_mispred;
        if (tag == "sat_mp")   return s_stat_mispred;
        return 32'hxxxx_xxxx;
    endfunction

    task automatic expect_v(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    // Start a step on the falling edge with the update port idle.
    task automatic step_begin();
        @(negedge clk);
        flush           = 1'b0;
        upd_valid       = 1'b0;
        upd_is_branch   = 1'b0;
        upd_pc          = 32'h0;
        upd_taken       = 1'b0;
        upd_target      = 32'h0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
    endtask

    task automatic upd(input logic br, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_is_branch   = br;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    // Let combinational outputs settle, then compare every queued expectation.
    task automatic drain();
        string       t;
        logic [31:0] e;
        #2;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            chk(t, observe(t), e);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        if_pc           = 32'h0040_0010;
        upd_valid       = 1'b0;
        upd_is_branch   = 1'b0;
        upd_pc          = 32'h0;
        upd_taken       = 1'b0;
        upd_target      = 32'h0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'h0;
        #12 rst_n = 1'b1;

        // S0: post-reset state
        step_begin();
        if_pc = 32'h0040_0010;
        expect_v("pred_tk", 0); expect_v("pred_tgt", 32'h0040_0014);
        expect_v("stat_br", 0); expect_v("stat_mp", 0); expect_v("sat_mp", 32'hFFFF_FFFE);
        expect_v("mispred", 0);
        drain();

        // S1: allocate taken branch; same-cycle lookup of that index sees old (empty) entry
        step_begin();
        if_pc = 32'h0040_0020;
        upd(1, 32'h0040_0020, 1, 32'h0040_0100, 0, 32'h0040_0024);
        expect_v("mispred", 1); expect_v("recov", 32'h0040_0100);
        expect_v("pred_tk", 0); expect_v("pred_tgt", 32'h0040_0024);
        drain();

        // S2: entry now predicts taken; non-branch predicted taken mispredicts
        step_begin();
        if_pc = 32'h0040_0020;
        upd(0, 32'h0040_0080, 0, 32'h0, 1, 32'h0040_0100);
        expect_v("pred_tk", 1); expect_v("pred_tgt", 32'h0040_0100);
        expect_v("mispred", 1); expect_v("recov", 32'h0040_0084);
        expect_v("stat_br", 1); expect_v("stat_mp", 1); expect_v("sat_mp", 32'hFFFF_FFFF);
        drain();

        // S3: aliasing PC misses; not-taken update drops counter WT->WNT
        step_begin();
        if_pc = 32'h0040_0060;
        upd(1, 32'h0040_0020, 0, 32'h0, 1, 32'h0040_0100);
        expect_v("pred_tk", 0); expect_v("pred_tgt", 32'h0040_0064);
        expect_v("mispred", 1); expect_v("recov", 32'h0040_0024);
        expect_v("stat_br", 1); expect_v("stat_mp", 2); expect_v("sat_mp", 32'hFFFF_FFFF);
        drain();

        // S4: WNT predicts not-taken; taken update (1 of 4)
        step_begin();
        if_pc = 32'h0040_0020;
        upd(1, 32'h0040_0020, 1, 32'h0040_0100, 0, 32'h0040_0024);
        expect_v("pred_tk", 0); expect_v("pred_tgt", 32'h0040_0024);
        expect_v("mispred", 1);
        drain();

        // S5: back at WT; correctly predicted taken (2 of 4)
        step_begin();
        upd(1, 32'h0040_0020, 1, 32'h0040_0100, 1, 32'h0040_0100);
        expect_v("pred_tk", 1); expect_v("mispred", 0); expect_v("recov", 32'h0040_0100);
        drain();

        // S6: taken with wrong predicted target (3 of 4)
        step_begin();
        upd(1, 32'h0040_0020, 1, 32'h0040_0100, 1, 32'h0040_0200);
        expect_v("mispred", 1); expect_v("recov", 32'h0040_0100);
        drain();

        // S7: taken, correct (4 of 4), counter held at ST
        step_begin();
        upd(1, 32'h0040_0020, 1, 32'h0040_0100, 1, 32'h0040_0100);
        expect_v("mispred", 0);
        drain();

        // S8: one not-taken from ST
        step_begin();
        upd(1, 32'h0040_0020, 0, 32'h0, 1, 32'h0040_0100);
        expect_v("pred_tk", 1); expect_v("mispred", 1); expect_v("recov", 32'h0040_0024);
        drain();

        // S9: ST->WT still predicts taken; non-branch hit invalidates the entry
        step_begin();
        upd(0, 32'h0040_0020, 0, 32'h0, 1, 32'h0040_0100);
        expect_v("pred_tk", 1); expect_v("pred_tgt", 32'h0040_0100);
        expect_v("stat_br", 7); expect_v("stat_mp", 6);
        expect_v("mispred", 1); expect_v("recov", 32'h0040_0024);
        drain();

        // S10: entry gone; flush together with a taken update
        step_begin();
        upd(1, 32'h0040_0030, 1, 32'h0040_0300, 0, 32'h0040_0034);
        flush = 1'b1;
        expect_v("pred_tk", 0); expect_v("pred_tgt", 32'h0040_0024);
        expect_v("mispred", 1); expect_v("recov", 32'h0040_0300);
        drain();

        // S11: update dropped by flush, stats still counted; allocate another entry
        step_begin();
        if_pc = 32'h0040_0030;
        upd(1, 32'h0040_0040, 1, 32'h0040_0400, 0, 32'h0040_0044);
        expect_v("pred_tk", 0); expect_v("pred_tgt", 32'h0040_0034);
        expect_v("stat_br", 8); expect_v("stat_mp", 8);
        drain();

        // S12: hit on new entry while flush is asserted (takes effect at the edge)
        step_begin();
        if_pc = 32'h0040_0040;
        flush = 1'b1;
        expect_v("pred_tk", 1); expect_v("pred_tgt", 32'h0040_0400); expect_v("mispred", 0);
        drain();

        // S13: flushed entry misses; stats survive flush
        step_begin();
        if_pc = 32'h0040_0040;
        expect_v("pred_tk", 0); expect_v("pred_tgt", 32'h0040_0044);
        expect_v("stat_br", 9); expect_v("stat_mp", 9); expect_v("mispred", 0);
        drain();

        // S14: asynchronous reset mid-run clears stats without a clock edge
        step_begin();
        rst_n = 1'b0;
        expect_v("stat_br", 0); expect_v("stat_mp", 0); expect_v("sat_mp", 32'hFFFF_FFFE);
        drain();
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with 2-bit saturating direction counters for the 5-stage pipeline. Looked up combinationally in IF with the fetch PC and trained from EX when a control instruction resolves. It replaces the fixed "assume not-taken, flush on taken" policy with predicted redirection plus a single resolve-time mispredict/recovery signal. It also keeps saturating performance counters for branches seen and mispredictions.

## Interface
- ENTRIES, 16, number of table entries; power of 2, at least 2; IDX_W = log2(ENTRIES)
- ADDR_W, 32, PC/target width; TAG_W = ADDR_W - IDX_W - 2
- CNT_INIT, 2'b01, counter value loaded at reset (weakly not-taken)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- flush  in  1  synchronous invalidate of all entries
- if_pc  in  ADDR_W  fetch PC to look up
- pred_taken  out  1  predict redirect for if_pc
- pred_target  out  ADDR_W  predicted next PC
- upd_valid  in  1  an instruction resolves in EX this cycle
- upd_is_branch  in  1  resolving instruction is a branch/jump
- upd_pc  in  ADDR_W  PC of resolving instruction
- upd_taken  in  1  actual direction
- upd_target  in  ADDR_W  actual taken target
- upd_pred_taken  in  1  prediction carried down the pipe with this instruction
- upd_pred_target  in  ADDR_W  predicted next PC carried down the pipe
- mispredict  out  1  flush IF/ID and ID/EX and redirect
- recovery_pc  out  ADDR_W  correct next PC
- stat_branches  out  32  resolved branch count
- stat_mispred  out  32  mispredict count

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2]. Each entry holds valid, tag, target and a 2-bit counter.
- **Lookup (combinational):**
  - hit = valid[idx] & (tag == stored tag).
  - pred_taken = hit & cnt[1].
  - pred_target = target when pred_taken, else if_pc + 4.
- **Resolve (combinational):**
  - actual = upd_is_branch & upd_taken.
  - mispredict = upd_valid & (actual ? !(upd_pred_taken & upd_pred_target == upd_target) : upd_pred_taken).
  - recovery_pc = actual ? upd_target : upd_pc + 4.
- **Update (clocked, upd_valid=1):**
  - Branch, hit: counter increments on taken and decrements on not-taken, saturating at 2'b11 and 2'b00. Target is rewritten on taken.
  - Branch, miss, taken: allocate (replace) the entry; valid=1, tag, target, counter=2'b10.
  - Branch, miss, not-taken: no change.
  - Non-branch that hits (aliasing): the entry is invalidated.
- **Stats:**
  - stat_branches increments on upd_valid & upd_is_branch.
  - stat_mispred increments on mispredict.
  - Both saturate at 32'hFFFF_FFFF.
  - flush does not clear them.
- **flush:** all valid bits clear at the next edge; counters and targets are kept. When flush and an update occur in the same cycle, flush wins and the update is dropped. Stats still count the update.

## Timing
- **Reset (asynchronous, reset=0):**
  - All valid=0, counters=CNT_INIT, stats=0.
  - Outputs then read pred_taken=0 and pred_target=if_pc+4.
  - mispredict follows its inputs.
- **Latency:**
  - Lookup and resolve have zero latency (same cycle).
  - Table writes are visible to lookups from the cycle after the edge.
- **Same-index collision:** when a lookup and an update target the same index in one cycle, the lookup sees pre-update contents; there is no bypass.
- **Reset deasserted mid-operation:** reset may deassert in any cycle; the first edge after release performs normal updates.
- **No handshake:** upd_valid is a single-cycle qualifier, and one update is accepted per cycle.

## Structure
- **Shared package bp_pkg holds:**
  - Counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - The allocate value WT.
  - Index/tag width helper functions.
- **Sub-module bp_sat_counter:** parametrised width, with inc/dec, saturation and a reset value. It is instantiated per table entry (2-bit) and for both stats (32-bit).
- **Table storage:** flops, not RAM, because flush and reset are single-cycle.

## Test plan
- **Reset:** release reset, if_pc=0x0040_0010 -> pred_taken=0, pred_target=0x0040_0014, both stats 0.
- **Allocate then predict:** taken branch at 0x0040_0020 to 0x0040_0100 with upd_pred_taken=0 -> mispredict=1, recovery_pc=0x0040_0100. Next cycle, if_pc=0x0040_0020 -> pred_taken=1, pred_target=0x0040_0100.
- **Hysteresis:** from WT, one not-taken update -> counter WNT, pred_taken=0. Four taken updates -> ST. One not-taken -> WT, still predicts taken.
- **Aliasing:** with ENTRIES=16, PCs 0x0040_0020 and 0x0040_0060 share index 8. Allocate 0x0040_0020, then look up 0x0040_0060 -> miss. A non-branch update at 0x0040_0020 -> entry invalidated.
- **flush and collision:**
  - flush together with a taken update -> no entry allocated; stat_branches still increments.
  - Same-cycle lookup of the updated index -> returns old data.
- **Stat saturation:** with stat_mispred forced to 32'hFFFF_FFFE, two mispredicts -> value holds at 32'hFFFF_FFFF.
